// File: rtl/dffn_chain_stim_pkg.sv
// Shared types and helpers for the negative-clock flop chain launch block.
package dffn_chain_stim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        PH_A = 1'b0,
        PH_B = 1'b1
    } phase_e;

    // Pattern bits plus the flush pulses needed to push the last bit out of the chain.
    function automatic int npulse(input int width, input int chain_len);
        return width + chain_len - 1;
    endfunction

endpackage

// File: rtl/dffn_chain_stim_chk.sv
// Expected-bit history for the chain under test and saturating mismatch counter.
module dffn_chain_stim_chk
    import dffn_chain_stim_pkg::*;
#(
    parameter int CHAIN_LEN = 4,
    parameter int ERR_W     = 8
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             clr,
    input  logic             push,
    input  logic             push_bit,
    input  logic             cmp_en,
    input  logic             Q_in,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

    logic [CHAIN_LEN-1:0] hist_r;
    logic [ERR_W-1:0]     err_r;
    logic                 mismatch_s;

    // The oldest history entry is the bit now expected at the chain output.
    always_comb begin
        mismatch_s = cmp_en & (Q_in ^ hist_r[CHAIN_LEN-1]);
    end

    // History of launched bits, one entry per capture pulse.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            hist_r <= {CHAIN_LEN{1'b0}};
        end else if (clr) begin
            hist_r <= {CHAIN_LEN{1'b0}};
        end else if (push) begin
            hist_r[0] <= push_bit;
            for (int i = 1; i < CHAIN_LEN; i++) begin
                hist_r[i] <= hist_r[i-1];
            end
        end
    end

    // Mismatch counter stops at all-ones rather than wrapping.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            err_r <= {ERR_W{1'b0}};
        end else if (clr) begin
            err_r <= {ERR_W{1'b0}};
        end else if (mismatch_s && (err_r != ERR_MAX)) begin
            err_r <= err_r + ERR_ONE;
        end
    end

    assign err_cnt = err_r;

endmodule

// File: rtl/dffn_chain_stim_tx.sv
// Launch side for dffn test chains: serialises a pattern MSB-first, pulses the
// chain clock and checks the looped-back chain output.
module dffn_chain_stim_tx
    import dffn_chain_stim_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CHAIN_LEN = 4,
    parameter int ERR_W     = 8
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic [WIDTH-1:0] pat_data,
    input  logic             pat_valid,
    output logic             pat_ready,
    output logic             D_out,
    output logic             CLKN_out,
    input  logic             Q_in,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int NPULSE = npulse(WIDTH, CHAIN_LEN);
    localparam int PCW    = $clog2(NPULSE + 1);
    localparam logic [PCW-1:0] LAST_PULSE = PCW'(NPULSE - 1);
    localparam logic [PCW-1:0] CMP_FIRST  = PCW'(CHAIN_LEN);
    localparam logic [PCW-1:0] PCNT_ONE   = PCW'(1);

    state_e           state_r;
    phase_e           phase_r;
    logic [WIDTH-1:0] shreg_r;
    logic [PCW-1:0]   pcnt_r;
    logic             d_out_r;
    logic             clkn_r;
    logic             busy_r;
    logic             done_r;
    logic             ready_r;

    logic             accept_s;
    logic             push_s;
    logic             cmp_en_s;

    // Handshake, history push and compare strobes decoded from state and phase.
    always_comb begin
        accept_s = 1'b0;
        push_s   = 1'b0;
        cmp_en_s = 1'b0;
        case (state_r)
            IDLE: begin
                accept_s = pat_valid & ready_r;
            end
            SHIFT: begin
                if (phase_r == PH_A) begin
                    cmp_en_s = (pcnt_r >= CMP_FIRST);
                end else begin
                    push_s = 1'b1;
                end
            end
            CHECK: begin
                cmp_en_s = 1'b1;
            end
            default: begin
                accept_s = 1'b0;
            end
        endcase
    end

    // FSM, shift register and pulse counter; D_out only moves when entering phase A.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_r <= IDLE;
            phase_r <= PH_A;
            shreg_r <= {WIDTH{1'b0}};
            pcnt_r  <= {PCW{1'b0}};
            d_out_r <= 1'b0;
            clkn_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (accept_s) begin
                        state_r <= SHIFT;
                        phase_r <= PH_A;
                        // shreg holds the bits still to be launched, next one at the MSB.
                        shreg_r <= {pat_data[WIDTH-2:0], 1'b0};
                        d_out_r <= pat_data[WIDTH-1];
                        clkn_r  <= 1'b0;
                        pcnt_r  <= {PCW{1'b0}};
                        busy_r  <= 1'b1;
                        ready_r <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (phase_r == PH_A) begin
                        phase_r <= PH_B;
                        clkn_r  <= 1'b1;
                    end else begin
                        clkn_r <= 1'b0;
                        if (pcnt_r == LAST_PULSE) begin
                            state_r <= CHECK;
                        end else begin
                            phase_r <= PH_A;
                            pcnt_r  <= pcnt_r + PCNT_ONE;
                            d_out_r <= shreg_r[WIDTH-1];
                            shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                CHECK: begin
                    state_r <= DONE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    phase_r <= PH_A;
                    clkn_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    dffn_chain_stim_chk #(
        .CHAIN_LEN (CHAIN_LEN),
        .ERR_W     (ERR_W)
    ) u_chk (
        .CLK      (CLK),
        .RN       (RN),
        .clr      (accept_s),
        .push     (push_s),
        .push_bit (d_out_r),
        .cmp_en   (cmp_en_s),
        .Q_in     (Q_in),
        .err_cnt  (err_cnt)
    );

    assign pat_ready = ready_r;
    assign D_out     = d_out_r;
    assign CLKN_out  = clkn_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_dffn_chain_stim_tx.sv
// Directed bench: three launch instances (16/4/8, 16/4/3, 2/1/8), each driving
// a behavioural dffn chain with an optional stuck-at stage.
module tb_dffn_chain_stim_tx;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RN;
    logic [15:0] pat0;
    logic [15:0] pat1;
    logic [1:0]  pat2;
    logic [2:0]  valid_v, ready_v, dout_v, clkn_v, q_v, busy_v, done_v;
    logic [7:0]  err0, err2;
    logic [2:0]  err1;
    logic [2:0]  fault_en, fault_val;
    logic [5:0]  fault_stg;

    int n_checks = 0;
    int n_errors = 0;

    dffn_chain_stim_tx #(.WIDTH(16), .CHAIN_LEN(4), .ERR_W(8)) u_dut (
        .CLK(CLK), .RN(RN), .pat_data(pat0), .pat_valid(valid_v[0]), .pat_ready(ready_v[0]),
        .D_out(dout_v[0]), .CLKN_out(clkn_v[0]), .Q_in(q_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .err_cnt(err0));

    dffn_chain_stim_tx #(.WIDTH(16), .CHAIN_LEN(4), .ERR_W(3)) u_sat (
        .CLK(CLK), .RN(RN), .pat_data(pat1), .pat_valid(valid_v[1]), .pat_ready(ready_v[1]),
        .D_out(dout_v[1]), .CLKN_out(clkn_v[1]), .Q_in(q_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .err_cnt(err1));

    dffn_chain_stim_tx #(.WIDTH(2), .CHAIN_LEN(1), .ERR_W(8)) u_small (
        .CLK(CLK), .RN(RN), .pat_data(pat2), .pat_valid(valid_v[2]), .pat_ready(ready_v[2]),
        .D_out(dout_v[2]), .CLKN_out(clkn_v[2]), .Q_in(q_v[2]), .busy(busy_v[2]),
        .done(done_v[2]), .err_cnt(err2));

    // Behavioural chains plus recorders of D_out / Q_in seen at each capture edge.
    for (genvar g = 0; g < 3; g++) begin : g_chain
        localparam int CL = (g == 2) ? 1 : 4;
        logic [3:0]  ch_r;
        logic [3:0]  st_s;
        logic [63:0] rec_d = 64'd0;
        logic [63:0] rec_q = 64'd0;
        int          n_edge = 0;

        always_comb begin
            st_s = ch_r;
            if (fault_en[g]) st_s[fault_stg[2*g +: 2]] = fault_val[g];
            else             st_s = ch_r;
        end

        always @(posedge clkn_v[g] or negedge RN) begin
            if (!RN) ch_r <= 4'b0000;
            else     ch_r <= {st_s[2:0], dout_v[g]};
        end

        assign q_v[g] = st_s[CL-1];

        always @(posedge clkn_v[g]) begin
            rec_d  <= {rec_d[62:0], dout_v[g]};
            rec_q  <= {rec_q[62:0], q_v[g]};
            n_edge <= n_edge + 1;
        end
    end

    function automatic int get_edges(input int idx);
        case (idx)
            0:       return g_chain[0].n_edge;
            1:       return g_chain[1].n_edge;
            default: return g_chain[2].n_edge;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_pat(input int idx, input logic [15:0] p);
        case (idx)
            0:       pat0 = p;
            1:       pat1 = p;
            default: pat2 = p[1:0];
        endcase
    endtask

    // Offer a pattern from a negedge, run to done, collect launched and returned streams.
    task automatic run_xfer(input int idx, input logic [15:0] pat, input bit keep_valid,
                            output int pulses, output int done_cyc, output int busy_cyc,
                            output logic [15:0] launched, output logic [15:0] qstr,
                            output logic [7:0] err, output int ready_bad);
        int w, n, cyc, start, k;
        logic [63:0] rd, rq;
        w = (idx == 2) ? 2 : 16;
        n = w + ((idx == 2) ? 1 : 4) - 1;
        k = 0;
        while (ready_v[idx] !== 1'b1 && k < 100) begin
            @(negedge CLK);
            k++;
        end
        chk("ready_wait", (k < 100) ? 32'd1 : 32'd0, 32'd1);
        start = get_edges(idx);
        set_pat(idx, pat);
        valid_v[idx] = 1'b1;
        @(posedge CLK);
        #1;
        if (keep_valid) set_pat(idx, ~pat);
        else            valid_v[idx] = 1'b0;
        cyc = 1; busy_cyc = 0; ready_bad = 0; done_cyc = -1;
        @(negedge CLK);
        while (cyc < 300) begin
            if (ready_v[idx]) ready_bad++;
            if (busy_v[idx])  busy_cyc++;
            if (done_v[idx]) begin
                done_cyc = cyc;
                break;
            end
            @(negedge CLK);
            cyc++;
        end
        pulses = get_edges(idx) - start;
        case (idx)
            0:       begin rd = g_chain[0].rec_d; rq = g_chain[0].rec_q; err = err0; end
            1:       begin rd = g_chain[1].rec_d; rq = g_chain[1].rec_q; err = {5'b00000, err1}; end
            default: begin rd = g_chain[2].rec_d; rq = g_chain[2].rec_q; err = err2; end
        endcase
        launched = 16'h0000;
        qstr     = 16'h0000;
        for (int i = 0; i < w; i++) launched[w-1-i] = rd[n-1-i];
        for (int i = 0; i < w - 1; i++) qstr[w-1-i] = rq[w-2-i];
        qstr[0] = q_v[idx];
    endtask

    typedef struct {
        int          idx;
        logic [15:0] pat;
        logic        fen;
        logic [1:0]  fstg;
        logic        fval;
        int          exp_pulses;
        int          exp_done;
        logic [7:0]  exp_err;
        bit          qcheck;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int pulses, done_cyc, busy_cyc, ready_bad, e0;
        logic [15:0] launched, qstr;
        logic [7:0] err;

        RN = 1'b0; pat0 = 16'h0000; pat1 = 16'h0000; pat2 = 2'b00;
        valid_v = 3'b000; fault_en = 3'b000; fault_val = 3'b000; fault_stg = 6'd0;

        vecs[0] = '{0, 16'hA5C3, 1'b0, 2'd0, 1'b0, 19, 40, 8'd0,  1'b1};
        vecs[1] = '{0, 16'h0000, 1'b1, 2'd1, 1'b1, 19, 40, 8'd16, 1'b0};
        vecs[2] = '{1, 16'hFFFF, 1'b1, 2'd1, 1'b0, 19, 40, 8'd7,  1'b0};
        vecs[3] = '{2, 16'h0002, 1'b0, 2'd0, 1'b0, 2,  6,  8'd0,  1'b1};
        vecs[4] = '{0, 16'hFFFF, 1'b0, 2'd0, 1'b0, 19, 40, 8'd0,  1'b1};
        vecs[5] = '{0, 16'h1234, 1'b1, 2'd3, 1'b0, 19, 40, 8'd5,  1'b0};
        vecs[6] = '{1, 16'h8001, 1'b0, 2'd0, 1'b0, 19, 40, 8'd0,  1'b1};
        vecs[7] = '{2, 16'h0001, 1'b1, 2'd0, 1'b1, 2,  6,  8'd1,  1'b0};

        repeat (3) @(negedge CLK);
        RN = 1'b1;
        @(negedge CLK);
        chk("rst_ready", {31'd0, ready_v[0]}, 32'd1);
        chk("rst_busy",  {29'd0, busy_v},     32'd0);
        chk("rst_done",  {29'd0, done_v},     32'd0);
        chk("rst_clkn",  {29'd0, clkn_v},     32'd0);
        chk("rst_dout",  {29'd0, dout_v},     32'd0);
        chk("rst_err",   {24'd0, err0},       32'd0);

        for (int i = 0; i < 8; i++) begin
            fault_en[vecs[i].idx]                 = vecs[i].fen;
            fault_val[vecs[i].idx]                = vecs[i].fval;
            fault_stg[2*vecs[i].idx +: 2]         = vecs[i].fstg;
            run_xfer(vecs[i].idx, vecs[i].pat, 1'b0, pulses, done_cyc, busy_cyc,
                     launched, qstr, err, ready_bad);
            chk($sformatf("v%0d_pulses", i), pulses, vecs[i].exp_pulses);
            chk($sformatf("v%0d_done_cyc", i), done_cyc, vecs[i].exp_done);
            chk($sformatf("v%0d_busy_cyc", i), busy_cyc, vecs[i].exp_done - 1);
            chk($sformatf("v%0d_err", i), {24'd0, err}, {24'd0, vecs[i].exp_err});
            chk($sformatf("v%0d_launched", i), {16'd0, launched}, {16'd0, vecs[i].pat});
            if (vecs[i].qcheck) chk($sformatf("v%0d_qstream", i), {16'd0, qstr}, {16'd0, vecs[i].pat});
            chk($sformatf("v%0d_ready_busy", i), ready_bad, 0);
            fault_en[vecs[i].idx] = 1'b0;
            @(negedge CLK);
            if (vecs[i].idx == 0) chk($sformatf("v%0d_err_hold", i), {24'd0, err0}, {24'd0, vecs[i].exp_err});
        end

        // Reset asserted in cycle 11 of a transfer.
        set_pat(0, 16'hA5C3);
        valid_v[0] = 1'b1;
        @(posedge CLK);
        #1 valid_v[0] = 1'b0;
        repeat (10) @(posedge CLK);
        #1 RN = 1'b0;
        #1;
        chk("midrst_outs", {28'd0, busy_v[0], done_v[0], clkn_v[0], dout_v[0]}, 32'd0);
        chk("midrst_err", {24'd0, err0}, 32'd0);
        e0 = get_edges(0);
        repeat (4) @(negedge CLK);
        chk("midrst_no_edges", get_edges(0) - e0, 0);
        RN = 1'b1;
        @(negedge CLK);
        chk("midrst_ready", {31'd0, ready_v[0]}, 32'd1);
        run_xfer(0, 16'h0001, 1'b0, pulses, done_cyc, busy_cyc, launched, qstr, err, ready_bad);
        chk("post_rst_err", {24'd0, err}, 32'd0);
        chk("post_rst_qstream", {16'd0, qstr}, 32'h0001);
        chk("post_rst_done_cyc", done_cyc, 40);

        // pat_valid held high through the run with pat_data changed after accept.
        @(negedge CLK);
        run_xfer(0, 16'h3C5A, 1'b1, pulses, done_cyc, busy_cyc, launched, qstr, err, ready_bad);
        chk("hs_launched", {16'd0, launched}, 32'h3C5A);
        chk("hs_ready_busy", ready_bad, 0);
        chk("hs_err", {24'd0, err}, 32'd0);
        @(negedge CLK);
        chk("hs_ready_idle", {31'd0, ready_v[0]}, 32'd1);
        chk("hs_busy_idle", {31'd0, busy_v[0]}, 32'd0);
        run_xfer(0, 16'hC3A5, 1'b0, pulses, done_cyc, busy_cyc, launched, qstr, err, ready_bad);
        chk("hs2_launched", {16'd0, launched}, 32'hC3A5);
        chk("hs2_done_cyc", done_cyc, 40);
        chk("hs2_ready_busy", ready_bad, 0);

        repeat (2) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
